// File: rtl/sram_sp_be.sv
// sram_sp_be: parametrised single-port synchronous SRAM with per-byte write
// enables, a registered read port with a read-valid strobe, and a hardware
// clear sequence that fills every word with INIT_VAL after each reset.
//
// Optional feature macro: SRAM_OUT_REG_EN
//   undefined (default) - one output register, read latency 1 cycle
//   defined             - extra output register stage, read latency 2 cycles
module sram_sp_be #(
  parameter int                  DATA_W   = 32,
  parameter int                  ADDR_W   = 10,
  parameter logic [DATA_W-1:0]   INIT_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wren,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     data,
  output logic [DATA_W-1:0]     q,
  output logic                  q_valid,
  output logic                  ready
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int BYTE_N = DATA_W / 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Merged write port: clear sequence or accepted user write.
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [BYTE_N-1:0]   wr_be;
  logic                rd_acc;

  // Stage-1 read register.
  logic [DATA_W-1:0]   q_s1;
  logic                v_s1;

  // Clear/idle sequencer; ready is registered alongside the state.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent behaviour.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      ready    <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + ADDR_W'(1);
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state <= ST_IDLE;
            ready <= 1'b1;
          end
        end
        ST_IDLE: begin
          ready <= 1'b1;
        end
        default: begin
          state <= ST_CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

  // Select the write source and qualify reads; en is ignored while clearing.
  // NOTE: every output gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
    rd_acc  = 1'b0;
    if (state == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr;
      wr_data = INIT_VAL;
      wr_be   = '1;
    end else if (en) begin
      wr_en  = wren;
      rd_acc = ~wren;
    end
  end

  // Byte-masked array write; a write coinciding with reset is dropped.
  // NOTE: the array has no reset term - a reset would turn the RAM into
  // flops; initialisation is the job of the clear sequence instead.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int i = 0; i < BYTE_N; i++) begin
        if (wr_be[i]) begin
          mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // First output register: captures read data on acceptance, holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_s1 <= '0;
      v_s1 <= 1'b0;
    end else begin
      v_s1 <= rd_acc;
      if (rd_acc) begin
        q_s1 <= mem[addr];
      end
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_W-1:0]   q_s2;
  logic                v_s2;

  // Second output register: delays data and strobe by one more cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_s2 <= '0;
      v_s2 <= 1'b0;
    end else begin
      v_s2 <= v_s1;
      if (v_s1) begin
        q_s2 <= q_s1;
      end
    end
  end

  assign q       = q_s2;
  assign q_valid = v_s2;
`else
  assign q       = q_s1;
  assign q_valid = v_s1;
`endif

endmodule

// File: tb/tb_sram_sp_be.sv
// Directed self-checking bench for sram_sp_be (DATA_W=32, ADDR_W=4).
module tb_sram_sp_be;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              wren;
  logic [3:0]        be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              q_valid;
  logic              ready;

  int total = 0;
  int bad   = 0;

  sram_sp_be #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INIT_VAL('0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .wren   (wren),
    .be     (be),
    .addr   (addr),
    .data   (data),
    .q      (q),
    .q_valid(q_valid),
    .ready  (ready)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are then sampled and inputs driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles until ready rises (bounded) and compare against DEPTH.
  task automatic count_clear(input string name);
    int n = 0;
    while (ready !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (ready !== 1'b1) begin
        total++;
        if (q_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s q_valid during clear: got %0b want 0", name, q_valid);
        end
      end
    end
    en = 1'b0;
    total++;
    if (n !== DEPTH) begin
      bad++;
      $display("FAIL %s clear cycles: got %0d want %0d", name, n, DEPTH);
    end
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [31:0] d,
                            input logic [3:0] b);
    en = 1'b1; wren = 1'b1; addr = a; data = d; be = b;
    tick();
    en = 1'b0; wren = 1'b0;
    total++;
    if (q_valid !== 1'b0) begin
      bad++;
      $display("FAIL write q_valid addr %0d: got %0b want 0", a, q_valid);
    end
  endtask

  // Single read: q_valid must appear exactly LAT cycles after acceptance.
  task automatic read_word(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
    en = 1'b1; wren = 1'b0; addr = a; be = 4'h0;
    for (int k = 1; k <= LAT + 1; k++) begin
      tick();
      en = 1'b0;
      total++;
      if (q_valid !== (k == LAT)) begin
        bad++;
        $display("FAIL read addr %0d q_valid at +%0d: got %0b want %0b",
                 a, k, q_valid, (k == LAT));
      end
      if (k == LAT) begin
        total++;
        if (q !== exp) begin
          bad++;
          $display("FAIL read addr %0d data: got %h want %h", a, q, exp);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; wren = 1'b0; be = 4'h0; addr = '0; data = '0;
    tick();
    tick();
    total++;
    if ({q, q_valid, ready} !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset outputs: got q=%h v=%0b r=%0b want 0/0/0", q, q_valid, ready);
    end
    rst_n = 1'b1;
    count_clear("reset");
    for (int i = 0; i < DEPTH; i++) read_word(ADDR_W'(i), 32'h0);
  endtask

  task automatic test_byte_enable();
    write_word(4'd5, 32'hAABBCCDD, 4'hF);
    write_word(4'd5, 32'h11223344, 4'b0101);
    read_word(4'd5, 32'hAA22CC44);
    write_word(4'd5, 32'hFFFFFFFF, 4'h0);
    read_word(4'd5, 32'hAA22CC44);
    write_word(4'd6, 32'h12345678, 4'b1010);
    read_word(4'd6, 32'h12005600);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp[0] = 32'h10; exp[1] = 32'h20; exp[2] = 32'h30; exp[3] = 32'h40;
    for (int i = 0; i < 4; i++) write_word(ADDR_W'(i), exp[i], 4'hF);
    for (int k = 1; k <= 4 + LAT; k++) begin
      if (k <= 4) begin
        en = 1'b1; wren = 1'b0; addr = ADDR_W'(k - 1);
      end else begin
        en = 1'b0;
      end
      tick();
      total++;
      if (q_valid !== (k >= LAT && k <= LAT + 3)) begin
        bad++;
        $display("FAIL b2b q_valid at +%0d: got %0b", k, q_valid);
      end
      if (k >= LAT) begin
        total++;
        if (q !== exp[(k - LAT > 3) ? 3 : k - LAT]) begin
          bad++;
          $display("FAIL b2b data at +%0d: got %h want %h", k, q,
                   exp[(k - LAT > 3) ? 3 : k - LAT]);
        end
      end
    end
  endtask

  task automatic test_clear_requests();
    write_word(4'd2, 32'h0BADF00D, 4'hF);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    en = 1'b1; wren = 1'b1; addr = 4'd2; data = 32'hDEADBEEF; be = 4'hF;
    count_clear("clear_req");
    wren = 1'b0;
    read_word(4'd2, 32'h0);
  endtask

  task automatic test_mid_reset();
    write_word(4'd7, 32'h55, 4'hF);
    en = 1'b1; wren = 1'b0; addr = 4'd7;
    tick();
    en = 1'b0;
    if (LAT == 1) begin
      total++;
      if (q !== 32'h55 || q_valid !== 1'b1) begin
        bad++;
        $display("FAIL pre-reset read: got %h/%0b want 00000055/1", q, q_valid);
      end
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++;
    if ({q, q_valid, ready} !== {32'h0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL mid reset outputs: got q=%h v=%0b r=%0b want 0/0/0", q, q_valid, ready);
    end
    count_clear("mid_reset");
    read_word(4'd7, 32'h0);
  endtask

  task automatic test_latency();
    write_word(4'd5, 32'hAABBCCDD, 4'hF);
    write_word(4'd5, 32'h11223344, 4'b0101);
    read_word(4'd5, 32'hAA22CC44);
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_clear_requests();
    test_mid_reset();
    test_latency();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_sp_be.md
Name: sram_sp_be

Overview:
- Parametrised single-port synchronous SRAM model. It succeeds the fixed 1024x32 memory model and is the backing store behind the AHB-lite slave memory.
- Adds configurable width and depth, per-byte write enables, a read-valid strobe, and a post-reset hardware clear sequence.
- One access per cycle (read or write). All outputs are registered.

Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8.
- ADDR_W, 10, address width; DEPTH = 2**ADDR_W words.
- INIT_VAL, 0, DATA_W-bit value written to every word during the clear sequence.

Ports:
- clk  in  1  clock; all logic samples on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- en  in  1  access request; qualified by ready.
- wren  in  1  1 = write, 0 = read; valid when en=1.
- be  in  DATA_W/8  byte write enables; be[i] covers data[8i+7:8i].
- addr  in  ADDR_W  word address.
- data  in  DATA_W  write data.
- q  out  DATA_W  read data, registered.
- q_valid  out  1  one-cycle strobe; q holds new read data.
- ready  out  1  1 = block accepts requests (clear sequence done).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - q=0, q_valid=0, ready=0.
  - FSM goes to CLEAR and clear counter clr_addr=0.
  - Array contents are not touched by reset itself.
- FSM states: CLEAR and IDLE.
- CLEAR:
  - Each cycle writes INIT_VAL to mem[clr_addr] with all bytes enabled, then clr_addr increments.
  - en is ignored.
  - When clr_addr = DEPTH-1 is written, go to IDLE next cycle. The clear takes exactly DEPTH cycles.
  - ready=0 throughout CLEAR. ready=1 from the first IDLE cycle.
- IDLE, request accepted when en=1 (ready=1 is implied in IDLE):
  - Write (wren=1): mem[addr] byte i <= data byte i only for each be[i]=1; all other bytes keep their value. be=0 is a legal no-op write. q and q_valid are unaffected, so q_valid=0 the next cycle.
  - Read (wren=0): q <= mem[addr] at the same edge; q_valid=1 for exactly one cycle after acceptance. Latency is 1 cycle.
  - be is ignored on reads.
- When no read is accepted, q holds its last value and q_valid=0.
- Back-to-back reads: one result per cycle; q_valid stays high continuously.
- Write then read of the same address in the next cycle returns the new data. No bypass is needed because there is one access per cycle.
- Reset during CLEAR or IDLE: the current operation is aborted and the clear restarts from address 0. A write presented in the same cycle as rst_n=0 is dropped.
- Addresses are always in range because DEPTH = 2**ADDR_W; there is no wrap or error logic. clr_addr wraps naturally but CLEAR exits before the wrap.

Optional Feature:
- Macro: SRAM_OUT_REG_EN.
- Defined: adds a second output register stage.
  - Read latency becomes 2 cycles.
  - q_valid is delayed to match.
  - Both stages reset to 0.
  - Back-to-back throughput is still 1 read per cycle.
  - Reset clears any in-flight read, so no q_valid appears after reset.
- Not defined: single output register, 1-cycle latency as above.

Test Plan:
- Reset, then hold en=0 with ADDR_W=4:
  - ready must be 0 for exactly 16 cycles after rst_n rises, then 1.
  - Reads of all 16 addresses return INIT_VAL=0.
- Byte-enable write:
  - write 0xAABBCCDD to addr 5 with be=4'hF;
  - then write 0x11223344 to addr 5 with be=4'b0101;
  - read addr 5 -> q=0xAA22CC44, with q_valid high 1 cycle after the read.
- Back-to-back reads:
  - preload addr 0..3 with 0x10,0x20,0x30,0x40;
  - four consecutive reads -> q=0x10,0x20,0x30,0x40 on successive cycles with q_valid continuously 1;
  - q holds 0x40 afterwards with q_valid=0.
- Requests during CLEAR:
  - issue write 0xDEADBEEF to addr 2 while ready=0;
  - after ready=1, read addr 2 -> 0x00000000.
- Mid-operation reset:
  - write 0x55 to addr 7, then reset;
  - pulse rst_n low for 1 cycle in IDLE;
  - ready drops for DEPTH cycles;
  - read addr 7 -> 0x00000000; q=0 and q_valid=0 immediately after reset.
- With SRAM_OUT_REG_EN defined:
  - read addr 5 after the byte-enable test -> q=0xAA22CC44 and q_valid exactly 2 cycles after acceptance, never after 1.
